// File: rtl/tbuf_drive_ctrl_pkg.sv
// Shared types and sizing helper for the tri-state bus drive controller.
package tbuf_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      TURN  = 2'd3
   } drv_state_e;

   // Bits needed to hold the larger of the two cycle counts, never below 1.
   function automatic int cnt_w(input int hold, input int turn);
      int m;
      m = (hold > turn) ? hold : turn;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tbuf_drive_ctrl_if.sv
// Upstream handshake plus tri-state buffer drive signals.
interface tbuf_drive_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic [WIDTH-1:0] bus_a;
   logic             bus_en;
   logic             busy;
   logic             xfer_done;

   modport master (
      output in_valid, in_data,
      input  in_ready, bus_a, bus_en, busy, xfer_done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, bus_a, bus_en, busy, xfer_done
   );
endinterface

// File: rtl/tbuf_drive_ctrl_cnt.sv
// Loadable down counter with zero flag; saturates at zero instead of wrapping.
module tbuf_drv_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/tbuf_drive_ctrl.sv
// Drives one word at a time onto a tri-state bus: one setup cycle, HOLD_CYC
// enable cycles, TURN_CYC release cycles; optional back-to-back bursting.
module tbuf_drive_ctrl
   import tbuf_drv_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int HOLD_CYC = 3,
   parameter int TURN_CYC = 2,
   parameter int BURST    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   tbuf_drive_ctrl_if.slave io
);
   localparam int           CW      = cnt_w(HOLD_CYC, TURN_CYC);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

   if (HOLD_CYC < 1) begin : g_bad_hold
      $error("tbuf_drive_ctrl: HOLD_CYC must be at least 1");
   end

   drv_state_e       state_q, state_d;
   logic [WIDTH-1:0] bus_a_q, bus_a_d;
   logic             bus_en_q, bus_en_d;
   logic             busy_q, busy_d;
   logic             xfer_done_q, xfer_done_d;
   logic             hold_ld, hold_dec, hold_zero;
   logic             turn_ld, turn_dec, turn_zero;
   logic             ready, accept;

   tbuf_drv_cnt #(.W(CW)) u_hold_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (hold_ld),
      .load_val_i(HOLD_LD),
      .dec_i     (hold_dec),
      .zero_o    (hold_zero)
   );

   tbuf_drv_cnt #(.W(CW)) u_turn_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (turn_ld),
      .load_val_i(TURN_LD),
      .dec_i     (turn_dec),
      .zero_o    (turn_zero)
   );

   // Ready depends only on state and counter so upstream can't form a loop.
   assign ready  = (state_q == IDLE) ||
                   ((BURST != 0) && (state_q == DRIVE) && hold_zero);
   assign accept = io.in_valid && ready;

   always_comb begin
      state_d     = state_q;
      bus_a_d     = bus_a_q;
      xfer_done_d = 1'b0;
      hold_ld     = 1'b0;
      hold_dec    = 1'b0;
      turn_ld     = 1'b0;
      turn_dec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               bus_a_d = io.in_data;
               state_d = SETUP;
            end
         end
         SETUP: begin
            hold_ld = 1'b1;
            state_d = DRIVE;
         end
         DRIVE: begin
            if (!hold_zero) begin
               hold_dec = 1'b1;
            end else begin
               xfer_done_d = 1'b1;
               if (accept) begin
                  bus_a_d = io.in_data;
                  hold_ld = 1'b1;
               end else if (TURN_CYC == 0) begin
                  state_d = IDLE;
               end else begin
                  turn_ld = 1'b1;
                  state_d = TURN;
               end
            end
         end
         TURN: begin
            if (turn_zero) state_d = IDLE;
            else           turn_dec = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      bus_en_d = (state_d == DRIVE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bus_a_q     <= '0;
         bus_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_a_q     <= bus_a_d;
         bus_en_q    <= bus_en_d;
         busy_q      <= busy_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign io.in_ready  = ready;
   assign io.bus_a     = bus_a_q;
   assign io.bus_en    = bus_en_q;
   assign io.busy      = busy_q;
   assign io.xfer_done = xfer_done_q;
endmodule

// File: tb/tb_tbuf_drive_ctrl.sv
// Bench: three controller variants (burst/turn=2, no-burst/turn=2, burst/turn=0)
// checked against a word-timeline model.
module tb_tbuf_drive_ctrl;
   localparam int W    = 8;
   localparam int HOLD = 3;
   localparam int MS   = 320;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   vld   = '0;
   logic [W-1:0] dat [3];
   logic         rdy [3];
   logic         en  [3];
   logic         bsy [3];
   logic         xd  [3];
   logic [W-1:0] ba  [3];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Expected outputs per cycle index (cycle c = interval after clock edge c).
   bit           m_en   [MS];
   bit           m_xd   [MS];
   bit           m_busy [MS];
   logic [W-1:0] m_a    [MS];
   int           m_idle_from;
   int           m_last;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      tbuf_drive_ctrl_if #(.WIDTH(W)) ifc ();
      tbuf_drive_ctrl #(
         .WIDTH   (W),
         .HOLD_CYC(HOLD),
         .TURN_CYC((g == 2) ? 0 : 2),
         .BURST   ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .io   (ifc)
      );
      assign ifc.in_valid = vld[g];
      assign ifc.in_data  = dat[g];
      assign rdy[g] = ifc.in_ready;
      assign en[g]  = ifc.bus_en;
      assign bsy[g] = ifc.busy;
      assign xd[g]  = ifc.xfer_done;
      assign ba[g]  = ifc.bus_a;
   end

   function automatic bit burst_of(int g);
      return g != 1;
   endfunction

   function automatic int turn_of(int g);
      return (g == 2) ? 0 : 2;
   endfunction

   function automatic void m_clear();
      for (int k = 0; k < MS; k++) begin
         m_en[k] = 1'b0; m_xd[k] = 1'b0; m_busy[k] = 1'b0; m_a[k] = '0;
      end
      m_idle_from = 0;
      m_last      = -10;
   endfunction

   function automatic bit m_ready(int g, int c);
      return (c >= m_idle_from) || (burst_of(g) && c == m_last);
   endfunction

   // Word accepted at edge e: a word taken while still driving skips setup.
   function automatic void m_accept(int g, int e, logic [W-1:0] w);
      int d;
      d = (e - 1 < m_idle_from) ? e : e + 1;
      for (int k = e; k < MS; k++) m_a[k] = w;
      for (int k = d; k < d + HOLD; k++) m_en[k] = 1'b1;
      m_xd[d + HOLD] = 1'b1;
      m_idle_from = d + HOLD + turn_of(g);
      for (int k = e; k < m_idle_from; k++) m_busy[k] = 1'b1;
      m_last = d + HOLD - 1;
   endfunction

   task automatic step(input int g, input bit v, input logic [W-1:0] w, output bit acc);
      vld[g] = v;
      dat[g] = w;
      acc = v && m_ready(g, cyc);
      if (acc) m_accept(g, cyc + 1, w);
      @(negedge clk); #1;
      cyc++;
   endtask

   task automatic do_reset();
      vld   = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      cyc = 0;
      m_clear();
   endtask

   task automatic test_reset();
      bit acc;
      rst_n = 1'b0;
      vld   = '1;
      for (int g = 0; g < 3; g++) dat[g] = W'($urandom);
      repeat (3) @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         if ({en[g], bsy[g], xd[g]} !== 3'b000 || ba[g] !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: en/busy/done=%b%b%b bus_a=%h, want 000 and 00",
                     g, en[g], bsy[g], xd[g], ba[g]);
         end
         n_chk++;
      end
      vld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cyc = 0;
      m_clear();
      for (int g = 0; g < 3; g++) begin
         if (rdy[g] !== 1'b1 || bsy[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle dut%0d: ready=%b busy=%b, want 1 0", g, rdy[g], bsy[g]);
         end
         n_chk++;
      end
      step(0, 1'b1, 8'h3C, acc);
      if (ba[0] !== 8'h3C || bsy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL first_accept: bus_a=%h busy=%b, want 3c 1", ba[0], bsy[0]);
      end
      n_chk++;
   endtask

   task automatic test_single_word();
      bit acc;
      int first_en, n_en, xd_at;
      first_en = -1; n_en = 0; xd_at = -1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (ba[0] !== m_a[cyc] || en[0] !== m_en[cyc] || xd[0] !== m_xd[cyc] ||
             rdy[0] !== m_ready(0, cyc)) begin
            n_fail++;
            $display("FAIL single_word cyc%0d: a=%h en=%b done=%b rdy=%b, want a=%h en=%b done=%b rdy=%b",
                     cyc, ba[0], en[0], xd[0], rdy[0], m_a[cyc], m_en[cyc], m_xd[cyc], m_ready(0, cyc));
         end
         n_chk++;
         if (en[0]) begin n_en++; if (first_en < 0) first_en = cyc; end
         if (xd[0] && xd_at < 0) xd_at = cyc;
         step(0, c == 0, (c == 0) ? 8'hA5 : 8'hFF, acc);
      end
      if (first_en != 2 || n_en != HOLD || xd_at != 5) begin
         n_fail++;
         $display("FAIL single_word_timing: en_first=%0d en_cycles=%0d done_at=%0d, want 2 3 5",
                  first_en, n_en, xd_at);
      end
      n_chk++;
   endtask

   task automatic test_back_to_back();
      bit acc;
      int sent, n_en, en_first, en_last, xd1, xd2;
      logic [W-1:0] a_at5;
      for (int g = 0; g < 2; g++) begin
         do_reset();
         sent = 0; n_en = 0; en_first = -1; en_last = -1; xd1 = -1; xd2 = -1; a_at5 = 'x;
         for (int c = 0; c < 18; c++) begin
            if (en[g] !== m_en[cyc] || xd[g] !== m_xd[cyc] || ba[g] !== m_a[cyc]) begin
               n_fail++;
               $display("FAIL back_to_back dut%0d cyc%0d: en=%b done=%b a=%h, want %b %b %h",
                        g, cyc, en[g], xd[g], ba[g], m_en[cyc], m_xd[cyc], m_a[cyc]);
            end
            n_chk++;
            if (en[g]) begin
               n_en++; en_last = cyc;
               if (en_first < 0) en_first = cyc;
            end
            if (xd[g]) begin
               if (xd1 < 0) xd1 = cyc; else xd2 = cyc;
            end
            if (cyc == 5) a_at5 = ba[g];
            step(g, sent < 2, (sent == 0) ? 8'h11 : 8'h22, acc);
            if (acc) sent++;
         end
         if (g == 0) begin
            if (n_en != 6 || en_last - en_first + 1 != 6 || xd1 != 5 || xd2 != 8 || a_at5 !== 8'h22) begin
               n_fail++;
               $display("FAIL burst_timing: en=%0d span=%0d done=%0d,%0d a@5=%h, want 6 6 5,8 22",
                        n_en, en_last - en_first + 1, xd1, xd2, a_at5);
            end
         end else begin
            // Low gap = two turn cycles, one idle cycle to accept, one setup cycle.
            if (n_en != 6 || en_last - en_first + 1 != 10 || xd1 != 5 || xd2 != 12) begin
               n_fail++;
               $display("FAIL noburst_timing: en=%0d span=%0d done=%0d,%0d, want 6 10 5,12",
                        n_en, en_last - en_first + 1, xd1, xd2);
            end
         end
         n_chk++;
      end
   endtask

   task automatic test_turn_zero();
      bit acc, prev_en;
      int fell;
      logic rdy_at_fell, bsy_at_fell;
      prev_en = 1'b0; fell = -1; rdy_at_fell = 'x; bsy_at_fell = 'x;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (rdy[2] !== m_ready(2, cyc) || bsy[2] !== m_busy[cyc] || en[2] !== m_en[cyc]) begin
            n_fail++;
            $display("FAIL turn_zero cyc%0d: rdy=%b busy=%b en=%b, want %b %b %b",
                     cyc, rdy[2], bsy[2], en[2], m_ready(2, cyc), m_busy[cyc], m_en[cyc]);
         end
         n_chk++;
         if (prev_en && !en[2] && fell < 0) begin
            fell = cyc; rdy_at_fell = rdy[2]; bsy_at_fell = bsy[2];
         end
         prev_en = en[2];
         step(2, c == 0, 8'h5A, acc);
      end
      if (fell != 5 || rdy_at_fell !== 1'b1 || bsy_at_fell !== 1'b0) begin
         n_fail++;
         $display("FAIL turn_zero_ready: fell=%0d rdy=%b busy=%b, want 5 1 0", fell, rdy_at_fell, bsy_at_fell);
      end
      n_chk++;
   endtask

   task automatic test_reset_mid_drive();
      bit acc;
      do_reset();
      step(0, 1'b1, 8'hC3, acc);
      step(0, 1'b0, 8'h00, acc);
      step(0, 1'b0, 8'h00, acc);
      if (en[0] !== 1'b1 || ba[0] !== 8'hC3) begin
         n_fail++;
         $display("FAIL mid_drive_setup: en=%b a=%h, want 1 c3", en[0], ba[0]);
      end
      n_chk++;
      #2 rst_n = 1'b0;
      #1;
      if (en[0] !== 1'b0 || ba[0] !== '0 || bsy[0] !== 1'b0 || xd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: en=%b a=%h busy=%b done=%b, want 0 00 0 0", en[0], ba[0], bsy[0], xd[0]);
      end
      n_chk++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int c = 0; c < 6; c++) begin
         if (xd[0] !== 1'b0 || en[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet c%0d: done=%b en=%b, want 0 0", c, xd[0], en[0]);
         end
         n_chk++;
         @(negedge clk); #1;
      end
   endtask

   task automatic test_turn_ignore();
      bit acc;
      logic [W-1:0] w0, w;
      w0 = 8'h96;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if (ba[1] !== m_a[cyc] || rdy[1] !== m_ready(1, cyc)) begin
            n_fail++;
            $display("FAIL turn_ignore cyc%0d: a=%h rdy=%b, want %h %b",
                     cyc, ba[1], rdy[1], m_a[cyc], m_ready(1, cyc));
         end
         n_chk++;
         if ((cyc == 5 || cyc == 6) && ba[1] !== w0) begin
            n_fail++;
            $display("FAIL turn_hold cyc%0d: a=%h, want %h", cyc, ba[1], w0);
         end
         if (cyc == 5 || cyc == 6) n_chk++;
         w = (c == 0) ? w0 : W'($urandom);
         step(1, 1'b1, w, acc);
      end
   endtask

   task automatic test_random();
      bit acc;
      for (int g = 0; g < 3; g++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            if (ba[g] !== m_a[cyc] || en[g] !== m_en[cyc] || xd[g] !== m_xd[cyc] ||
                bsy[g] !== m_busy[cyc] || rdy[g] !== m_ready(g, cyc)) begin
               n_fail++;
               $display("FAIL random dut%0d cyc%0d: a=%h en=%b done=%b busy=%b rdy=%b, want %h %b %b %b %b",
                        g, cyc, ba[g], en[g], xd[g], bsy[g], rdy[g],
                        m_a[cyc], m_en[cyc], m_xd[cyc], m_busy[cyc], m_ready(g, cyc));
            end
            n_chk++;
            step(g, $urandom_range(0, 3) != 0, W'($urandom), acc);
         end
      end
   endtask

   initial begin
      for (int g = 0; g < 3; g++) dat[g] = '0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_turn_zero();
      test_reset_mid_drive();
      test_turn_ignore();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
